// File: rtl/tmds_line_sequencer_if.sv
// tmds_line_sequencer_if: line-request, pixel and encoder-load signals between sequencer and encoder pipeline
// master: sequencer side (takes line_start/pix_valid, drives pix_req, loads, out_sel, status)
// slave:  requester/encoder side
interface tmds_line_sequencer_if;
  logic       line_start;
  logic       pix_valid;
  logic       pix_req;
  logic       line_busy;
  logic       D1_load;
  logic       D2_load;
  logic       S1_load;
  logic       L2_load;
  logic       S2_load;
  logic       enc_s_rst;
  logic [1:0] out_sel;
  logic       underrun;
  modport master (
    input  line_start, pix_valid,
    output pix_req, line_busy, D1_load, D2_load, S1_load, L2_load, S2_load, enc_s_rst, out_sel, underrun
  );
  modport slave (
    output line_start, pix_valid,
    input  pix_req, line_busy, D1_load, D2_load, S1_load, L2_load, S2_load, enc_s_rst, out_sel, underrun
  );
endinterface

// File: rtl/tmds_line_sequencer.sv
// tmds_line_sequencer: per-line CONTROL/PREAMBLE/GUARD/VIDEO sequencing with pipelined encoder load enables
// clk, s_rst : character clock, synchronous active-high reset
// bus        : tmds_line_sequencer_if.master (line_start, pix_valid in; pix_req, loads, enc_s_rst, out_sel, line_busy, underrun out)
// TMDS_SEQ_UNDERRUN_EN : when defined, a pixel request without pix_valid sets the sticky underrun flag
module tmds_line_sequencer #(
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2,
  parameter int LINE_PIXELS  = 640,
  parameter int CTRL_MIN     = 12
) (
  input logic clk,
  input logic s_rst,
  tmds_line_sequencer_if.master bus
);
  localparam int LINE_LEN = PREAMBLE_LEN + GUARD_LEN + LINE_PIXELS;
  localparam int PW = $clog2(LINE_LEN + 1);
  localparam int CW = CTRL_MIN > 0 ? $clog2(CTRL_MIN + 1) : 1;
  typedef enum logic [1:0] {CONTROL, PREAMBLE, GUARD, VIDEO} state_t;
  state_t state, state_n;
  logic [PW-1:0] pos;
  logic [CW-1:0] cnt;
  logic [3:0] taps;
  logic d1;
  logic [1:0] sel_n;
  // pos counts characters from PREAMBLE entry; the first pixel is fetched 5 cycles
  // before VIDEO so it emerges from the 5-stage encoder exactly on the first VIDEO cycle
  always_comb begin
    state_n = state == CONTROL  ? ((bus.line_start && cnt >= CW'(CTRL_MIN)) ? PREAMBLE : CONTROL)
            : state == PREAMBLE ? (pos == PW'(PREAMBLE_LEN - 1) ? GUARD : PREAMBLE)
            : state == GUARD    ? (pos == PW'(PREAMBLE_LEN + GUARD_LEN - 1) ? VIDEO : GUARD)
            :                     (pos == PW'(LINE_LEN - 1) ? CONTROL : VIDEO);
    d1 = state != CONTROL && pos >= PW'(PREAMBLE_LEN + GUARD_LEN - 5) && pos <= PW'(LINE_LEN - 6);
    sel_n = state_n == VIDEO ? 2'b00 : state_n == GUARD ? 2'b10 : 2'b01;
  end
  always_ff @(posedge clk) begin
    if (s_rst) begin
      state         <= CONTROL;
      pos           <= '0;
      cnt           <= '0;
      taps          <= '0;
      bus.out_sel   <= 2'b01;
      bus.enc_s_rst <= 1'b0;
    end else begin
      state         <= state_n;
      pos           <= (state == CONTROL || state_n == CONTROL) ? '0 : pos + PW'(1);
      cnt           <= state != CONTROL ? '0 : cnt == CW'(CTRL_MIN) ? cnt : cnt + CW'(1);
      taps          <= {taps[2:0], d1};
      bus.out_sel   <= sel_n;
      bus.enc_s_rst <= state == VIDEO && state_n == CONTROL;
    end
  end
  assign bus.pix_req   = d1;
  assign bus.D1_load   = d1;
  assign bus.D2_load   = taps[0];
  assign bus.S1_load   = taps[1];
  assign bus.L2_load   = taps[2];
  assign bus.S2_load   = taps[3];
  assign bus.line_busy = state != CONTROL || d1 || |taps;
`ifdef TMDS_SEQ_UNDERRUN_EN
  always_ff @(posedge clk) begin
    if (s_rst) bus.underrun <= 1'b0;
    else if (d1 && !bus.pix_valid) bus.underrun <= 1'b1;
  end
`else
  assign bus.underrun = 1'b0;
`endif
endmodule

// File: tb/tb_tmds_line_sequencer.sv
// tb_tmds_line_sequencer: directed checks of line timing, load pipeline, reset abort, back-to-back lines and underrun
module tb_tmds_line_sequencer;
  logic clk = 1'b0;
  logic s_rst;
  int errors = 0;
  int checks = 0;
`ifdef TMDS_SEQ_UNDERRUN_EN
  localparam bit UR_EN = 1'b1;
`else
  localparam bit UR_EN = 1'b0;
`endif
  tmds_line_sequencer_if bus();
  tmds_line_sequencer #(.PREAMBLE_LEN(8), .GUARD_LEN(2), .LINE_PIXELS(4), .CTRL_MIN(12)) dut (
    .clk(clk),
    .s_rst(s_rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [4:0] loads();
    return {bus.S2_load, bus.L2_load, bus.S1_load, bus.D2_load, bus.D1_load};
  endfunction
  task automatic idle_chk(input string tag);
    chk({tag, " sel"}, {6'd0, bus.out_sel}, 8'h01);
    chk({tag, " loads"}, {3'd0, loads()}, 8'h00);
    chk({tag, " pix_req"}, {7'd0, bus.pix_req}, 8'h00);
    chk({tag, " enc_s_rst"}, {7'd0, bus.enc_s_rst}, 8'h00);
    chk({tag, " busy"}, {7'd0, bus.line_busy}, 8'h00);
  endtask
  // Called in the cycle where line_start is sampled (T); checks T+1..T+15.
  task automatic run_line(input string name, input bit drop, input bit hold, input bit ur_base);
    logic [1:0] e_sel;
    logic [4:0] e_ld;
    logic e_ur;
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      if (k == 1 && !hold) bus.line_start = 1'b0;
      e_sel = k <= 8 ? 2'b01 : k <= 10 ? 2'b10 : k <= 14 ? 2'b00 : 2'b01;
      for (int i = 0; i < 5; i++) e_ld[i] = k >= 6 + i && k <= 9 + i;
      e_ur = UR_EN && (ur_base || (drop && k >= 8));
      chk($sformatf("%s k%0d sel", name, k), {6'd0, bus.out_sel}, {6'd0, e_sel});
      chk($sformatf("%s k%0d loads", name, k), {3'd0, loads()}, {3'd0, e_ld});
      chk($sformatf("%s k%0d pix_req", name, k), {7'd0, bus.pix_req}, {7'd0, e_ld[0]});
      chk($sformatf("%s k%0d enc_s_rst", name, k), {7'd0, bus.enc_s_rst}, {7'd0, k == 15});
      chk($sformatf("%s k%0d busy", name, k), {7'd0, bus.line_busy}, {7'd0, k <= 14});
      chk($sformatf("%s k%0d underrun", name, k), {7'd0, bus.underrun}, {7'd0, e_ur});
      bus.pix_valid = !(drop && k == 7);
    end
  endtask
  initial begin
    s_rst = 1'b1;
    bus.line_start = 1'b0;
    bus.pix_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 s_rst = 1'b0;
    idle_chk("reset");
    chk("reset underrun", {7'd0, bus.underrun}, 8'h00);
    tick(5);
    bus.line_start = 1'b1;
    tick(1);
    bus.line_start = 1'b0;
    chk("early start ignored busy", {7'd0, bus.line_busy}, 8'h00);
    chk("early start ignored sel", {6'd0, bus.out_sel}, 8'h01);
    tick(6);
    bus.line_start = 1'b1;
    run_line("line1", 1'b1, 1'b0, 1'b0);
    bus.line_start = 1'b1;
    tick(12);
    chk("b2b gap busy", {7'd0, bus.line_busy}, 8'h00);
    chk("b2b gap sel", {6'd0, bus.out_sel}, 8'h01);
    run_line("line2", 1'b0, 1'b1, 1'b1);
    tick(12);
    chk("b2b gap2 busy", {7'd0, bus.line_busy}, 8'h00);
    chk("b2b gap2 underrun", {7'd0, bus.underrun}, {7'd0, UR_EN});
    tick(1);
    chk("line3 start busy", {7'd0, bus.line_busy}, 8'h01);
    bus.line_start = 1'b0;
    tick(10);
    s_rst = 1'b1;
    tick(1);
    s_rst = 1'b0;
    idle_chk("abort");
    chk("abort underrun", {7'd0, bus.underrun}, 8'h00);
    tick(2);
    bus.line_start = 1'b1;
    tick(1);
    bus.line_start = 1'b0;
    chk("post-abort start ignored", {7'd0, bus.line_busy}, 8'h00);
    tick(9);
    bus.line_start = 1'b1;
    run_line("line4", 1'b0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tmds_line_sequencer.md
TMDS_LINE_SEQUENCER -- requirements
Module: tmds_line_sequencer

Interface
REQ-001 The block SHALL have parameter PREAMBLE_LEN, 8, preamble characters per line (min 1).
REQ-002 The block SHALL have parameter GUARD_LEN, 2, guard-band characters per line; PREAMBLE_LEN+GUARD_LEN >= 5.
REQ-003 The block SHALL have parameter LINE_PIXELS, 640, video characters per line (min 1).
REQ-004 The block SHALL have parameter CTRL_MIN, 12, minimum control characters between lines.
REQ-005 The block SHALL have one clock and a synchronous active-high reset: clk  in  1  character clock; s_rst  in  1  synchronous reset.
REQ-006 Ports: line_start  in  1  request one line; pix_valid  in  1  upstream pixel present.
REQ-007 Ports: pix_req  out  1  pixel consumed this cycle; line_busy  out  1  high outside CONTROL.
REQ-008 Ports: D1_load, D2_load, S1_load, L2_load, S2_load  out  1 each  encoder stage load enables.
REQ-009 Ports: enc_s_rst  out  1  stage-2 disparity clear; out_sel  out  2  00 video, 01 preamble/control, 10 guard.
REQ-010 Ports: underrun  out  1  sticky missing-pixel flag.

Function
REQ-011 FSM states SHALL be CONTROL, PREAMBLE, GUARD, VIDEO; one state change at most per clk.
REQ-012 CONTROL SHALL count characters (saturating at CTRL_MIN); line_start with count >= CTRL_MIN moves to PREAMBLE next cycle; otherwise line_start ignored.
REQ-013 PREAMBLE SHALL last exactly PREAMBLE_LEN cycles, GUARD exactly GUARD_LEN cycles, VIDEO exactly LINE_PIXELS cycles, then CONTROL with count cleared.
REQ-014 out_sel SHALL be 01 in CONTROL/PREAMBLE, 10 in GUARD, 00 in VIDEO, registered with the state.
REQ-015 Let V be first VIDEO cycle; pix_req and D1_load SHALL be high for cycles V-5 .. V-6+LINE_PIXELS, i.e. starting PREAMBLE_LEN+GUARD_LEN-5 cycles after PREAMBLE entry.
REQ-016 D2_load, S1_load, L2_load, S2_load SHALL be D1_load delayed 1, 2, 3, 4 cycles respectively, so pixel k reaches S2 output at V+k.
REQ-017 enc_s_rst SHALL pulse one cycle on the first CONTROL cycle after VIDEO and be otherwise low.
REQ-018 line_busy SHALL be high whenever state != CONTROL or any load enable is high.
REQ-019 line_start during PREAMBLE/GUARD/VIDEO SHALL be ignored and not queued.
REQ-020 Counters SHALL be sized $clog2(max+1) and never wrap mid-line.

Reset
REQ-021 s_rst high at a clk edge SHALL force CONTROL, control count 0, out_sel=01, all loads/pix_req/enc_s_rst/underrun low next cycle.
REQ-022 s_rst mid-line SHALL abort the line; in-flight load delay taps SHALL clear; no partial line resumes.
REQ-023 After reset release, line_start SHALL be honoured only after CTRL_MIN control cycles.

Configuration
REQ-024 Macro TMDS_SEQ_UNDERRUN_EN defined: pix_req high with pix_valid low SHALL set underrun (cleared only by s_rst); sequencing unchanged.
REQ-025 Macro TMDS_SEQ_UNDERRUN_EN undefined: pix_valid SHALL be ignored and underrun tied 0.

Verification (PREAMBLE_LEN=8, GUARD_LEN=2, LINE_PIXELS=4, CTRL_MIN=12)
REQ-026 Reset, wait 12 cycles, pulse line_start at T -> PREAMBLE T+1..T+8, GUARD T+9..T+10, VIDEO T+11..T+14, out_sel 01/10/00, CONTROL at T+15 with enc_s_rst high one cycle.
REQ-027 Same stimulus -> D1_load/pix_req high T+6..T+9, S2_load high T+10..T+13, each intermediate load shifted by one cycle.
REQ-028 line_start 5 cycles after reset and again at cycle 12 -> first ignored, second starts PREAMBLE next cycle.
REQ-029 Assert s_rst at T+11 -> next cycle all loads low, out_sel=01, CONTROL; line_start at T+14 ignored.
REQ-030 Macro defined, pix_valid low at T+7 -> underrun set from T+8, stays high through next line until s_rst; macro undefined -> underrun 0.
REQ-031 Back-to-back: line_start held high continuously -> lines begin exactly every 8+2+4+12+1=27 cycles.
